mul_seq_ctrl: RTL and testbench

- Iterative shift-add multiply sequencer for the multi-cycle core. The main FSM raises start when the decoded instruction is MUL (opMul).
- The block computes Rn*Rm over WIDTH cycles.
- It holds busy so the FSM stalls in its execute state, then pulses done together with the result and the N/Z flags for the condition logic.
- Replaces the single-cycle ALU MUL path (ALUControl 3'b100).

---
 rtl/mul_seq_pkg.sv | 20 ++
 rtl/mul_seq_ctrl_if.sv | 26 ++
 rtl/mul_seq_datapath.sv | 42 ++++
 rtl/mul_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants for the iterative multiply sequencer and the instruction decoder.
package mul_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // ALU control encoding of MUL, kept here so the decoder and this block agree
  localparam logic [2:0] ALUCTRL_MUL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the main FSM (master) and the multiply sequencer (slave).
interface mul_seq_ctrl_if #(
  parameter int unsigned WIDTH = mul_seq_pkg::DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic [1:0]       state;

  modport master (
    output start, src_a, src_b,
    input  busy, done, result, flag_n, flag_z, state
  );

  modport slave (
    input  start, src_a, src_b,
    output busy, done, result, flag_n, flag_z, state
  );

endinterface

// File: rtl/mul_seq_datapath.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier.
module mul_seq_datapath #(
  parameter int unsigned WIDTH = mul_seq_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] acc_nxt_c,
  output logic             mplier_nxt_zero_c
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;

  // Accumulator value after the current step; carry out of the top bit is dropped
  always_comb begin
    acc_nxt_c         = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_nxt_zero_c = ((mplier_q >> 1) == '0);
  end

  // Load operands on start, otherwise advance one bit per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= src_a;
      mplier_q <= src_b;
    end else if (step) begin
      acc_q    <= acc_nxt_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative multiply sequencer: IDLE -> RUN (WIDTH steps) -> DONE, result and N/Z flags latched at completion.
// Optional early termination when the remaining multiplier bits are zero: define MUL_SEQ_EARLY_TERM_EN.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  mul_seq_ctrl_if.slave      bus
);

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, fin;
  logic             busy_q, done_q, flag_n_q, flag_z_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_nxt_c;
  logic             mplier_nxt_zero_c;

  mul_seq_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk               (clk),
    .reset             (reset),
    .load              (load),
    .step              (step),
    .src_a             (bus.src_a),
    .src_b             (bus.src_b),
    .acc_nxt_c         (acc_nxt_c),
    .mplier_nxt_zero_c (mplier_nxt_zero_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, datapath controls and iteration count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if ((cnt_q == LAST_CNT) || (EARLY_TERM && mplier_nxt_zero_c)) begin
          fin     = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, status and result registers; result only moves on the RUN->DONE edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (state_d == ST_RUN);
      done_q <= (state_d == ST_DONE);
      if (fin) begin
        result_q <= acc_nxt_c;
        flag_n_q <= acc_nxt_c[WIDTH-1];
        flag_z_q <= (acc_nxt_c == '0);
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_n = flag_n_q;
  assign bus.flag_z = flag_z_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (follows MUL_SEQ_EARLY_TERM_EN if defined).
module tb_mul_seq_ctrl;

  localparam int unsigned WIDTH = 32;

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RUN cycles expected for a given multiplier
  function automatic int exp_lat(input logic [31:0] b);
    int hb;
    hb = 1;
    for (int i = 0; i < 32; i++) if (b[i]) hb = i + 1;
    return EARLY ? hb : 32;
  endfunction

  // Issue one start and observe 40 cycles; optionally pulse a (9,9) start in cycle pulse_cyc
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_cyc,
                        output int dcyc, output int bcnt, output int dcnt);
    dcyc = 0; bcnt = 0; dcnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        dcnt++;
        if (dcyc == 0) dcyc = c;
      end
      if (c == pulse_cyc) begin
        bus.start = 1'b1; bus.src_a = 32'd9; bus.src_b = 32'd9;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic exp_n, input logic exp_z,
                               input int pulse_cyc);
    int dcyc, bcnt, dcnt;
    run_op(a, b, pulse_cyc, dcyc, bcnt, dcnt);
    check_val({tag, "_done_cyc"}, 64'(dcyc), 64'(exp_lat(b) + 1));
    check_val({tag, "_busy_cnt"}, 64'(bcnt), 64'(exp_lat(b)));
    check_val({tag, "_done_cnt"}, 64'(dcnt), 64'd1);
    check_val({tag, "_result"},   64'(bus.result), 64'(exp_res));
    check_val({tag, "_flag_n"},   64'(bus.flag_n), 64'(exp_n));
    check_val({tag, "_flag_z"},   64'(bus.flag_z), 64'(exp_z));
    check_val({tag, "_state"},    64'(bus.state), 64'd0);
  endtask

  initial begin
    int c, c2, dcnt, rst_cyc, ign_cyc;
    n_cmp = 0; n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_state",  64'(bus.state),  64'd0);
    check_val("rst_busy",   64'(bus.busy),   64'd0);
    check_val("rst_done",   64'(bus.done),   64'd0);
    check_val("rst_result", 64'(bus.result), 64'd0);
    check_val("rst_flags",  64'({bus.flag_n, bus.flag_z}), 64'd0);
    @(negedge clk); reset = 1'b1;

    run_and_check("mul7x6",   32'd7,          32'd6, 32'd42,         1'b0, 1'b0, 0);
    run_and_check("wrap_neg", 32'hFFFFFFFF,   32'd2, 32'hFFFFFFFE,   1'b1, 1'b0, 0);
    run_and_check("wrap_zero", 32'h80000000,  32'd2, 32'd0,          1'b0, 1'b1, 0);
    run_and_check("zero_b",   32'd1234,       32'd0, 32'd0,          1'b0, 1'b1, 0);

    // start pulse during RUN must be ignored (earlier pulse when RUN is short)
    ign_cyc = EARLY ? 2 : 10;
    run_and_check("ign_start", 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, ign_cyc);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.src_a = 32'd4; bus.src_b = 32'd5;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk); c = 1;
    while (!bus.done && c < 40) begin @(negedge clk); c++; end
    check_val("b2b_done1_cyc", 64'(c), 64'(exp_lat(32'd5) + 1));
    check_val("b2b_result1",   64'(bus.result), 64'd20);
    bus.start = 1'b1; bus.src_a = 32'd6; bus.src_b = 32'd7;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    check_val("b2b_busy_next",  64'(bus.busy),   64'd1);
    check_val("b2b_state_next", 64'(bus.state),  64'd1);
    check_val("b2b_result_hold", 64'(bus.result), 64'd20);
    c2 = 1;
    while (!bus.done && c2 < 40) begin @(negedge clk); c2++; end
    check_val("b2b_done2_cyc", 64'(c2), 64'(exp_lat(32'd7) + 1));
    check_val("b2b_result2",   64'(bus.result), 64'd42);
    repeat (3) @(negedge clk);

    // reset in the middle of RUN
    rst_cyc = EARLY ? 5 : 12;
    dcnt = 0;
    bus.start = 1'b1; bus.src_a = 32'd100; bus.src_b = 32'd100;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int i = 1; i <= rst_cyc; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check_val("mid_busy_pre", 64'(bus.busy), 64'd1);
    check_val("mid_no_done",  64'(dcnt),     64'd0);
    reset = 1'b0;
    #1;
    check_val("mid_state",  64'(bus.state),  64'd0);
    check_val("mid_busy",   64'(bus.busy),   64'd0);
    check_val("mid_done",   64'(bus.done),   64'd0);
    check_val("mid_result", 64'(bus.result), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_and_check("post_rst", 32'd2, 32'd3, 32'd6, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
